// File: rtl/road_segment_scheduler.sv
// road_segment_scheduler
//   Decides the next top-row road x position once per 2**FRAME_DIV_LOG2 frames and
//   offers it to the road shifter over a valid/ready handshake. Segments (straight or
//   curved, left or right, 64..127 ticks long) are drawn from an external LFSR. The
//   road bounces off the left/right limits.
// Ports
//   pixel_clk  : sole clock
//   rst        : synchronous active-high reset
//   h_coord    : current pixel x
//   v_coord    : current pixel y
//   rand_in    : free-running LFSR value, sampled only in the LOAD state
//   step_ready : road shifter accepts a step
//   step_valid : a new road_x is offered
//   road_x     : new top-row road left edge, px
//   seg_state  : FSM state code (0 LOAD, 1 LINE, 2 CURVE_IN, 3 CURVE_OUT)
//   seg_left   : remaining ticks in the current segment
//   overrun    : sticky, a tick was dropped because a step was still unaccepted
module road_segment_scheduler #(
  parameter int unsigned H_PIXELS       = 800,
  parameter int unsigned V_PIXELS       = 600,
  parameter int unsigned ROAD_WIDTH     = 90,
  parameter int unsigned BORDER_WIDTH   = 250,
  parameter int unsigned FRAME_DIV_LOG2 = 1,
  parameter int unsigned MAX_SLOPE      = 4
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic [10:0] h_coord,
  input  logic [9:0]  v_coord,
  input  logic [15:0] rand_in,
  input  logic        step_ready,
  output logic        step_valid,
  output logic [10:0] road_x,
  output logic [2:0]  seg_state,
  output logic [7:0]  seg_left,
  output logic        overrun
);

  localparam logic [10:0]        CENTER_X  = 11'(H_PIXELS / 2 - ROAD_WIDTH / 2);
  localparam logic signed [11:0] LEFT_LIM  = 12'(H_PIXELS / 2 - BORDER_WIDTH);
  localparam logic signed [11:0] RIGHT_LIM = 12'(H_PIXELS / 2 + BORDER_WIDTH - ROAD_WIDTH);
  localparam int unsigned        DIV_W     = (FRAME_DIV_LOG2 > 0) ? FRAME_DIV_LOG2 : 1;

  typedef enum logic [2:0] {
    StLoad     = 3'd0,
    StLine     = 3'd1,
    StCurveIn  = 3'd2,
    StCurveOut = 3'd3
  } state_e;

  state_e             state_q, state_d;
  logic [10:0]        road_x_q, road_x_d;
  logic               step_valid_q, step_valid_d;
  logic [7:0]         seg_left_q, seg_left_d;
  logic [7:0]         len_q, len_d;
  logic [2:0]         slope_q, slope_d;
  logic               dir_q, dir_d;
  logic [3:0]         phase_q, phase_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               overrun_q, overrun_d;

  logic               eof, tick, accept, transfer;
  logic [2:0]         mag;
  logic signed [11:0] delta, sum;
  logic               hit_left, hit_right;
  logic [7:0]         seg_left_dec;
  logic               unused_rand;

  assign unused_rand = ^{rand_in[15:10], rand_in[7:6]};

  // State register
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q      <= StLoad;
      road_x_q     <= CENTER_X;
      step_valid_q <= 1'b0;
      seg_left_q   <= 8'd0;
      len_q        <= 8'd0;
      slope_q      <= 3'd1;
      dir_q        <= 1'b1;
      phase_q      <= 4'd0;
      div_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      road_x_q     <= road_x_d;
      step_valid_q <= step_valid_d;
      seg_left_q   <= seg_left_d;
      len_q        <= len_d;
      slope_q      <= slope_d;
      dir_q        <= dir_d;
      phase_q      <= phase_d;
      div_q        <= div_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    eof      = (h_coord == 11'(H_PIXELS - 1)) && (v_coord == 10'(V_PIXELS - 1));
    tick     = eof && ((FRAME_DIV_LOG2 == 0) || (&div_q));
    // LOAD never consumes a tick; one arriving there is dropped like any other.
    accept   = tick && (state_q != StLoad) && (!step_valid_q || step_ready);
    transfer = step_valid_q && step_ready;

    mag          = (state_q == StLine) ? 3'd1 : slope_q;
    delta        = dir_q ? $signed({9'd0, mag}) : -$signed({9'd0, mag});
    sum          = $signed({1'b0, road_x_q}) + delta;
    hit_left     = (sum <= LEFT_LIM);
    hit_right    = (sum >= RIGHT_LIM);
    seg_left_dec = seg_left_q - 8'd1;

    state_d      = state_q;
    road_x_d     = road_x_q;
    seg_left_d   = seg_left_q;
    len_d        = len_q;
    slope_d      = slope_q;
    dir_d        = dir_q;
    phase_d      = phase_q;
    div_d        = eof ? div_q + DIV_W'(1) : div_q;
    overrun_d    = overrun_q | (tick & ~accept);
    step_valid_d = accept ? 1'b1 : (transfer ? 1'b0 : step_valid_q);

    if (state_q == StLoad) begin
      len_d      = {2'b01, rand_in[5:0]};
      seg_left_d = {2'b01, rand_in[5:0]};
      dir_d      = rand_in[9];
      slope_d    = 3'd1;
      phase_d    = 4'd0;
      state_d    = rand_in[8] ? StCurveIn : StLine;
    end else if (accept) begin
      seg_left_d = seg_left_dec;
      if (hit_left || hit_right) begin
        road_x_d = hit_left ? LEFT_LIM[10:0] : RIGHT_LIM[10:0];
        dir_d    = hit_left;
        slope_d  = 3'd1;
        state_d  = StLine;
      end else begin
        road_x_d = sum[10:0];
        // phase counts ticks within a curve half; the slope moves after every 16th.
        // The tick that turns CURVE_IN into CURVE_OUT restarts the count.
        if (state_q == StCurveIn) begin
          if (seg_left_q <= {1'b0, len_q[7:1]}) begin
            state_d = StCurveOut;
            phase_d = 4'd0;
          end else begin
            phase_d = phase_q + 4'd1;
            if ((phase_q == 4'd15) && (slope_q < 3'(MAX_SLOPE))) slope_d = slope_q + 3'd1;
          end
        end else if (state_q == StCurveOut) begin
          phase_d = phase_q + 4'd1;
          if ((phase_q == 4'd15) && (slope_q > 3'd1)) slope_d = slope_q - 3'd1;
        end
      end
      if (seg_left_dec == 8'd0) state_d = StLoad;
    end
  end

  // Outputs
  always_comb begin
    step_valid = step_valid_q;
    road_x     = road_x_q;
    seg_state  = state_q;
    seg_left   = seg_left_q;
    overrun    = overrun_q;
  end

endmodule
